// File: rtl/instr_mem_loader_pkg.sv
// Shared types and constants for the instruction-memory loader.
package instr_mem_loader_pkg;

  localparam int unsigned INSTR_W = 32;
  localparam logic [INSTR_W-1:0] NOP_INSTR = 32'h0;

  typedef enum logic [2:0] {
    StIdle,
    StLoad,
    StFill,
    StLoaded,
    StRun
  } state_e;

endpackage

// File: rtl/instr_mem_ram.sv
// Single-port N x 32 instruction RAM: synchronous write, registered read.
module instr_mem_ram
  import instr_mem_loader_pkg::*;
#(
  parameter int unsigned Depth = 256,
  parameter int unsigned AddrW = $clog2(Depth)
) (
  input  logic               clk_i,
  input  logic               we_i,
  input  logic               re_i,
  input  logic [AddrW-1:0]   addr_i,
  input  logic [INSTR_W-1:0] wdata_i,
  output logic [INSTR_W-1:0] rdata_o
);

  logic [INSTR_W-1:0] mem_q [Depth];
  logic [INSTR_W-1:0] rdata_q;

  // Write wins; the loader never requests both in one cycle.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[addr_i] <= wdata_i;
    end else if (re_i) begin
      rdata_q <= mem_q[addr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/instr_mem_loader.sv
// Loads a program from a host word stream, then serves instruction fetches while running.
// Optional zero-fill of unused words after a short program: define INSTR_ZERO_FILL_EN.
module instr_mem_loader
  import instr_mem_loader_pkg::*;
#(
  parameter int unsigned N = 256
) (
  input  logic                  CLK,
  input  logic                  RSTN,
  input  logic                  LOAD_REQ,
  input  logic [31:0]           HOST_WDATA,
  input  logic                  HOST_WVALID,
  input  logic                  HOST_WLAST,
  output logic                  HOST_WREADY,
  output logic                  LOAD_DONE,
  output logic                  LOAD_ERR,
  output logic [$clog2(N):0]    WORD_COUNT,
  input  logic                  START_SIGNAL,
  input  logic                  STOP_SIGNAL,
  input  logic [$clog2(N)-1:0]  PC_AXI,
  output logic [31:0]           INSTR_AXI
);

  localparam int unsigned AW = $clog2(N);
  localparam logic [AW-1:0] LastAddr = AW'(N - 1);

  state_e             state_q, state_d;
  logic [AW-1:0]      ptr_q, ptr_d;
  logic [AW:0]        count_q, count_d;
  logic               err_q, err_d;
  logic               rd_valid_q, rd_valid_d;

  logic               ram_we;
  logic               ram_re;
  logic [AW-1:0]      ram_addr;
  logic [INSTR_W-1:0] ram_wdata;
  logic [INSTR_W-1:0] ram_rdata;

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    count_d   = count_q;
    err_d     = err_q;
    ram_we    = 1'b0;
    ram_wdata = HOST_WDATA;

    unique case (state_q)
      StIdle: begin
        if (LOAD_REQ) begin
          state_d = StLoad;
          ptr_d   = '0;
          count_d = '0;
          err_d   = 1'b0;
        end
      end

      StLoad: begin
        // A restart request discards any word offered in the same cycle.
        if (LOAD_REQ) begin
          ptr_d   = '0;
          count_d = '0;
        end else if (HOST_WVALID) begin
          ram_we  = 1'b1;
          count_d = count_q + 1'b1;
          if (ptr_q == LastAddr) begin
            if (HOST_WLAST) begin
              state_d = StLoaded;
            end else begin
              err_d   = 1'b1;
              state_d = StIdle;
            end
          end else begin
            ptr_d = ptr_q + 1'b1;
            if (HOST_WLAST) begin
`ifdef INSTR_ZERO_FILL_EN
              state_d = StFill;
`else
              state_d = StLoaded;
`endif
            end
          end
        end
      end

      StFill: begin
`ifdef INSTR_ZERO_FILL_EN
        if (LOAD_REQ) begin
          state_d = StLoad;
          ptr_d   = '0;
          count_d = '0;
          err_d   = 1'b0;
        end else begin
          ram_we    = 1'b1;
          ram_wdata = NOP_INSTR;
          if (ptr_q == LastAddr) begin
            state_d = StLoaded;
          end else begin
            ptr_d = ptr_q + 1'b1;
          end
        end
`else
        state_d = StIdle;
`endif
      end

      StLoaded: begin
        if (LOAD_REQ) begin
          state_d = StLoad;
          ptr_d   = '0;
          count_d = '0;
          err_d   = 1'b0;
        end else if (START_SIGNAL) begin
          state_d = StRun;
        end
      end

      StRun: begin
        if (STOP_SIGNAL) begin
          state_d = StLoaded;
        end
      end

      default: state_d = StIdle;
    endcase
  end

  // Fetch data is only presented for cycles that will be spent in RUN.
  assign rd_valid_d = (state_d == StRun);
  assign ram_re     = rd_valid_d;
  assign ram_addr   = ram_we ? ptr_q : PC_AXI;

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      state_q    <= StIdle;
      ptr_q      <= '0;
      count_q    <= '0;
      err_q      <= 1'b0;
      rd_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      count_q    <= count_d;
      err_q      <= err_d;
      rd_valid_q <= rd_valid_d;
    end
  end

  instr_mem_ram #(
    .Depth (N),
    .AddrW (AW)
  ) u_ram (
    .clk_i   (CLK),
    .we_i    (ram_we),
    .re_i    (ram_re),
    .addr_i  (ram_addr),
    .wdata_i (ram_wdata),
    .rdata_o (ram_rdata)
  );

  assign HOST_WREADY = (state_q == StLoad);
  assign LOAD_DONE   = (state_q == StLoaded) || (state_q == StRun);
  assign LOAD_ERR    = err_q;
  assign WORD_COUNT  = count_q;
  assign INSTR_AXI   = rd_valid_q ? ram_rdata : NOP_INSTR;

endmodule

// File: tb/tb_instr_mem_loader.sv
// Self-checking bench for instr_mem_loader: directed tables, random loads and fetches.
module tb_instr_mem_loader;

  localparam int unsigned N  = 8;
  localparam int unsigned AW = $clog2(N);

  logic          CLK = 1'b0;
  logic          RSTN;
  logic          LOAD_REQ;
  logic [31:0]   HOST_WDATA;
  logic          HOST_WVALID;
  logic          HOST_WLAST;
  logic          HOST_WREADY;
  logic          LOAD_DONE;
  logic          LOAD_ERR;
  logic [AW:0]   WORD_COUNT;
  logic          START_SIGNAL;
  logic          STOP_SIGNAL;
  logic [AW-1:0] PC_AXI;
  logic [31:0]   INSTR_AXI;

  instr_mem_loader #(
    .N (N)
  ) dut (
    .CLK          (CLK),
    .RSTN         (RSTN),
    .LOAD_REQ     (LOAD_REQ),
    .HOST_WDATA   (HOST_WDATA),
    .HOST_WVALID  (HOST_WVALID),
    .HOST_WLAST   (HOST_WLAST),
    .HOST_WREADY  (HOST_WREADY),
    .LOAD_DONE    (LOAD_DONE),
    .LOAD_ERR     (LOAD_ERR),
    .WORD_COUNT   (WORD_COUNT),
    .START_SIGNAL (START_SIGNAL),
    .STOP_SIGNAL  (STOP_SIGNAL),
    .PC_AXI       (PC_AXI),
    .INSTR_AXI    (INSTR_AXI)
  );

  always #5 CLK = ~CLK;

  int errors = 0;
  int checks = 0;

  // Reference image of what the program memory must hold.
  logic [31:0] model_mem [N];

  typedef struct {
    logic [AW-1:0] pc;
    logic [31:0]   exp;
  } rd_vec_t;

  rd_vec_t vecs [8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_wready"}, 32'(HOST_WREADY), 32'd0);
    check({tag, "_done"},   32'(LOAD_DONE),   32'd0);
    check({tag, "_err"},    32'(LOAD_ERR),    32'd0);
    check({tag, "_count"},  32'(WORD_COUNT),  32'd0);
    check({tag, "_instr"},  INSTR_AXI,        32'd0);
  endtask

  task automatic pulse_load();
    LOAD_REQ = 1'b1;
    step();
    LOAD_REQ = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] d, input logic last, input bit jitter);
    if (jitter) begin
      for (int k = 0; k < 4 && $urandom_range(0, 2) == 0; k++) begin
        HOST_WVALID = 1'b0;
        HOST_WDATA  = $urandom;
        HOST_WLAST  = 1'($urandom_range(0, 1));
        step();
      end
    end
    check("wready_before_word", 32'(HOST_WREADY), 32'd1);
    HOST_WVALID = 1'b1;
    HOST_WDATA  = d;
    HOST_WLAST  = last;
    step();
    HOST_WVALID = 1'b0;
    HOST_WLAST  = 1'b0;
  endtask

  // Streams n fresh words (LAST on the final one) and updates the model,
  // including the zero image a fill build leaves behind.
  task automatic load_prog(input int n, input bit jitter);
    logic [31:0] d;
    for (int i = 0; i < n; i++) begin
      d = $urandom;
      model_mem[i] = d;
      send_word(d, (i == n - 1), jitter);
    end
`ifdef INSTR_ZERO_FILL_EN
    for (int i = n; i < int'(N); i++) model_mem[i] = 32'h0;
`endif
  endtask

  task automatic wait_done(input string name, input int exp_cycles);
    int cyc;
    cyc = 0;
    while (!LOAD_DONE && cyc < 20) begin
      check({name, "_wready_fill"}, 32'(HOST_WREADY), 32'd0);
      step();
      cyc++;
    end
    check({name, "_cycles"}, 32'(cyc), 32'(exp_cycles));
  endtask

  function automatic int fill_cycles(input int n);
`ifdef INSTR_ZERO_FILL_EN
    return int'(N) - n;
`else
    return 0;
`endif
  endfunction

  task automatic read_pc(input logic [AW-1:0] pc, input string name);
    PC_AXI = pc;
    step();
    check(name, INSTR_AXI, model_mem[pc]);
  endtask

  initial begin
    logic [31:0] d;
    LOAD_REQ = 0; HOST_WDATA = 0; HOST_WVALID = 0; HOST_WLAST = 0;
    START_SIGNAL = 0; STOP_SIGNAL = 0; PC_AXI = 0;
    RSTN = 1'b1;
    #2 RSTN = 1'b0;
    #10;
    check_reset_outputs("reset");
    @(negedge CLK) RSTN = 1'b1;
    step();

    // Directed 4-word program and table-driven fetches.
    pulse_load();
    check("load_wready", 32'(HOST_WREADY), 32'd1);
    send_word(32'h11, 1'b0, 1'b0);
    send_word(32'h22, 1'b0, 1'b0);
    send_word(32'h33, 1'b0, 1'b0);
    send_word(32'h44, 1'b1, 1'b0);
    model_mem[0] = 32'h11; model_mem[1] = 32'h22;
    model_mem[2] = 32'h33; model_mem[3] = 32'h44;
`ifdef INSTR_ZERO_FILL_EN
    for (int i = 4; i < int'(N); i++) model_mem[i] = 32'h0;
`endif
    wait_done("prog4", fill_cycles(4));
    check("prog4_count",  32'(WORD_COUNT),  32'd4);
    check("prog4_done",   32'(LOAD_DONE),   32'd1);
    check("prog4_err",    32'(LOAD_ERR),    32'd0);
    check("prog4_wready", 32'(HOST_WREADY), 32'd0);
    check("prog4_instr",  INSTR_AXI,        32'd0);

    vecs = '{'{3'd0, 32'h11}, '{3'd1, 32'h22}, '{3'd2, 32'h33}, '{3'd3, 32'h44},
             '{3'd3, 32'h44}, '{3'd1, 32'h22}, '{3'd2, 32'h33}, '{3'd0, 32'h11}};
    START_SIGNAL = 1'b1;
    for (int i = 0; i < 8; i++) begin
      PC_AXI = vecs[i].pc;
      step();
      START_SIGNAL = 1'b0;
      check($sformatf("fetch_tbl%0d", i), INSTR_AXI, vecs[i].exp);
    end

    // Host writes and load requests are ignored while running.
    LOAD_REQ = 1'b1; HOST_WVALID = 1'b1; HOST_WDATA = 32'hdeadbeef; HOST_WLAST = 1'b1;
    PC_AXI = 0;
    check("run_wready_comb", 32'(HOST_WREADY), 32'd0);
    step();
    check("run_wready", 32'(HOST_WREADY), 32'd0);
    check("run_done",   32'(LOAD_DONE),   32'd1);
    check("run_instr0", INSTR_AXI,        32'h11);
    step();
    LOAD_REQ = 1'b0; HOST_WVALID = 1'b0; HOST_WLAST = 1'b0;
    for (int i = 0; i < 4; i++) read_pc(AW'(i), "run_mem_intact");
    check("run_count_intact", 32'(WORD_COUNT), 32'd4);
    STOP_SIGNAL = 1'b1;
    step();
    STOP_SIGNAL = 1'b0;
    check("stop_instr_zero", INSTR_AXI,       32'd0);
    check("stop_done",       32'(LOAD_DONE),  32'd1);
    step();
    check("loaded_instr_zero", INSTR_AXI, 32'd0);

    // LOAD_REQ beats START_SIGNAL; then a jittered random 8-word load.
    LOAD_REQ = 1'b1; START_SIGNAL = 1'b1;
    step();
    LOAD_REQ = 1'b0; START_SIGNAL = 1'b0;
    check("prio_done",   32'(LOAD_DONE),   32'd0);
    check("prio_wready", 32'(HOST_WREADY), 32'd1);
    check("prio_instr",  INSTR_AXI,        32'd0);
    check("prio_count",  32'(WORD_COUNT),  32'd0);
    load_prog(8, 1'b1);
    wait_done("prog8", 0);
    check("prog8_count", 32'(WORD_COUNT), 32'd8);
    START_SIGNAL = 1'b1;
    read_pc(0, "prog8_first");
    START_SIGNAL = 1'b0;
    for (int i = 0; i < 24; i++) read_pc(AW'($urandom_range(0, N - 1)), "prog8_rand");
    STOP_SIGNAL = 1'b1;
    step();
    STOP_SIGNAL = 1'b0;

    // Overflow: N words without LAST, then an extra word.
    pulse_load();
    for (int i = 0; i < int'(N); i++) begin
      d = $urandom;
      model_mem[i] = d;
      send_word(d, 1'b0, 1'b0);
    end
    check("ovf_err",    32'(LOAD_ERR),    32'd1);
    check("ovf_done",   32'(LOAD_DONE),   32'd0);
    check("ovf_wready", 32'(HOST_WREADY), 32'd0);
    check("ovf_count",  32'(WORD_COUNT),  32'(N));
    HOST_WVALID = 1'b1; HOST_WDATA = 32'hbad0bad0; START_SIGNAL = 1'b1;
    step();
    HOST_WVALID = 1'b0; START_SIGNAL = 1'b0;
    check("ovf_extra_count", 32'(WORD_COUNT), 32'(N));
    check("ovf_extra_err",   32'(LOAD_ERR),   32'd1);
    check("idle_start_done", 32'(LOAD_DONE),  32'd0);
    check("idle_start_instr", INSTR_AXI,      32'd0);

    // Restart mid-load with a simultaneous word, then a short program.
    pulse_load();
    check("restart_err_clr", 32'(LOAD_ERR), 32'd0);
    send_word(32'h01234567, 1'b0, 1'b0);
    send_word(32'h89abcdef, 1'b0, 1'b0);
    check("restart_pre_count", 32'(WORD_COUNT), 32'd2);
    LOAD_REQ = 1'b1; HOST_WVALID = 1'b1; HOST_WDATA = 32'hfeedface;
    step();
    LOAD_REQ = 1'b0; HOST_WVALID = 1'b0;
    check("restart_count", 32'(WORD_COUNT), 32'd0);
    load_prog(3, 1'b0);
    wait_done("prog3", fill_cycles(3));
    check("prog3_count", 32'(WORD_COUNT), 32'd3);
    START_SIGNAL = 1'b1;
    read_pc(0, "prog3_first");
    START_SIGNAL = 1'b0;
    for (int i = 1; i < int'(N); i++) read_pc(AW'(i), "prog3_read");
    STOP_SIGNAL = 1'b1;
    step();
    STOP_SIGNAL = 1'b0;

    // Reset pulsed mid-load.
    pulse_load();
    send_word($urandom, 1'b0, 1'b0);
    send_word($urandom, 1'b0, 1'b0);
    @(negedge CLK) RSTN = 1'b0;
    #1;
    check_reset_outputs("midload_rst");
    step();
    @(negedge CLK) RSTN = 1'b1;
    step();
    check("post_rst_done", 32'(LOAD_DONE), 32'd0);
    check("post_rst_wready", 32'(HOST_WREADY), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
